// File: rtl/tx_tlp_arbiter.sv
// Two-source arbiter for the PCIe TX local-link. Port 0 is the posted-write engine and port 1 is the completion engine.
// Each grant covers one whole packet. Grants alternate round-robin on ties, and each port is granted only when its trn_tbuf_av bit is set.
module tx_tlp_arbiter #(
  parameter int P0_BUF_BIT = 1,
  parameter int P1_BUF_BIT = 2,
  parameter int CNT_W      = 16
) (
  input  logic             trn_clk,
  input  logic             trn_reset,
  input  logic             trn_lnk_up_n,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             abort0,
  output logic             abort1,
  input  logic [63:0]      s0_td,
  input  logic [63:0]      s1_td,
  input  logic [7:0]       s0_trem_n,
  input  logic [7:0]       s1_trem_n,
  input  logic             s0_tsof_n,
  input  logic             s1_tsof_n,
  input  logic             s0_teof_n,
  input  logic             s1_teof_n,
  input  logic             s0_tsrc_rdy_n,
  input  logic             s1_tsrc_rdy_n,
  output logic             s0_tdst_rdy_n,
  output logic             s1_tdst_rdy_n,
  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  input  logic             trn_tdst_rdy_n,
  input  logic             trn_tdst_dsc_n,
  input  logic [3:0]       trn_tbuf_av,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER0 = 2'd1, XFER1 = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             abort0_q, abort0_d, abort1_q, abort1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             elig0, elig1, kill, eof_accept;
  logic             unused_buf_bits;

  assign elig0      = req0 & trn_tbuf_av[P0_BUF_BIT] & ~trn_lnk_up_n;
  assign elig1      = req1 & trn_tbuf_av[P1_BUF_BIT] & ~trn_lnk_up_n;
  assign kill       = ~trn_tdst_dsc_n | trn_lnk_up_n;
  assign eof_accept = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n & ~trn_teof_n;
  assign unused_buf_bits = ^trn_tbuf_av;

  // last_q = 1 means port 1 won the previous tie, so port 0 wins the next one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    abort0_d = 1'b0;
    abort1_d = 1'b0;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    case (state_q)
      IDLE: begin
        if (elig0 && elig1) begin
          state_d = last_q ? XFER0 : XFER1;
          last_d  = ~last_q;
        end else if (elig0) begin
          state_d = XFER0;
        end else if (elig1) begin
          state_d = XFER1;
        end
      end
      XFER0: begin
        if (kill) begin
          state_d  = IDLE;
          abort0_d = 1'b1;
        end else if (eof_accept) begin
          state_d = IDLE;
          cnt0_d  = cnt0_q + 1'b1;
        end
      end
      XFER1: begin
        if (kill) begin
          state_d  = IDLE;
          abort1_d = 1'b1;
        end else if (eof_accept) begin
          state_d = IDLE;
          cnt1_d  = cnt1_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge trn_clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled on the clock edge.
    if (trn_reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      abort0_q <= 1'b0;
      abort1_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      abort0_q <= abort0_d;
      abort1_q <= abort1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  // Zero-latency data mux steered only by the registered state.
  always_comb begin
    trn_td         = '0;
    trn_trem_n     = '0;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    s0_tdst_rdy_n  = 1'b1;
    s1_tdst_rdy_n  = 1'b1;
    case (state_q)
      XFER0: begin
        trn_td         = s0_td;
        trn_trem_n     = s0_trem_n;
        trn_tsof_n     = s0_tsof_n;
        trn_teof_n     = s0_teof_n;
        trn_tsrc_rdy_n = s0_tsrc_rdy_n;
        s0_tdst_rdy_n  = trn_tdst_rdy_n;
      end
      XFER1: begin
        trn_td         = s1_td;
        trn_trem_n     = s1_trem_n;
        trn_tsof_n     = s1_tsof_n;
        trn_teof_n     = s1_teof_n;
        trn_tsrc_rdy_n = s1_tsrc_rdy_n;
        s1_tdst_rdy_n  = trn_tdst_rdy_n;
      end
      default: ;
    endcase
  end

  assign gnt0     = (state_q == XFER0);
  assign gnt1     = (state_q == XFER1);
  assign abort0   = abort0_q;
  assign abort1   = abort1_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Self-checking bench for tx_tlp_arbiter. It runs grant-decision vectors, hand-written packet sequences, and a randomized run against a reference model.
// The counter width is narrowed so the wrap case completes in a short run.
module tb_tx_tlp_arbiter;
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             trn_clk, trn_reset, trn_lnk_up_n, req0, req1;
  logic             gnt0, gnt1, abort0, abort1;
  logic [63:0]      s0_td, s1_td, trn_td;
  logic [7:0]       s0_trem_n, s1_trem_n, trn_trem_n;
  logic             s0_tsof_n, s1_tsof_n, s0_teof_n, s1_teof_n;
  logic             s0_tsrc_rdy_n, s1_tsrc_rdy_n, s0_tdst_rdy_n, s1_tdst_rdy_n;
  logic             trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic             trn_tdst_rdy_n, trn_tdst_dsc_n;
  logic [3:0]       trn_tbuf_av;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  tx_tlp_arbiter #(.P0_BUF_BIT(1), .P1_BUF_BIT(2), .CNT_W(CNT_W)) dut (
    .trn_clk(trn_clk), .trn_reset(trn_reset), .trn_lnk_up_n(trn_lnk_up_n),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .abort0(abort0), .abort1(abort1),
    .s0_td(s0_td), .s1_td(s1_td), .s0_trem_n(s0_trem_n), .s1_trem_n(s1_trem_n),
    .s0_tsof_n(s0_tsof_n), .s1_tsof_n(s1_tsof_n), .s0_teof_n(s0_teof_n), .s1_teof_n(s1_teof_n),
    .s0_tsrc_rdy_n(s0_tsrc_rdy_n), .s1_tsrc_rdy_n(s1_tsrc_rdy_n),
    .s0_tdst_rdy_n(s0_tdst_rdy_n), .s1_tdst_rdy_n(s1_tdst_rdy_n),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tdst_dsc_n(trn_tdst_dsc_n),
    .trn_tbuf_av(trn_tbuf_av), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    @(negedge trn_clk);
  endtask

  task automatic set_src(input int p, input logic [63:0] td, input logic [7:0] trem,
                         input logic sof_n, input logic eof_n, input logic rdy_n);
    if (p == 0) begin
      s0_td = td; s0_trem_n = trem; s0_tsof_n = sof_n; s0_teof_n = eof_n; s0_tsrc_rdy_n = rdy_n;
    end else begin
      s1_td = td; s1_trem_n = trem; s1_tsof_n = sof_n; s1_teof_n = eof_n; s1_tsrc_rdy_n = rdy_n;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 1) ? gnt1 : gnt0;
  endfunction
  function automatic logic abort_of(input int p);
    return (p == 1) ? abort1 : abort0;
  endfunction
  function automatic logic dst_of(input int p);
    return (p == 1) ? s1_tdst_rdy_n : s0_tdst_rdy_n;
  endfunction
  function automatic logic [CNT_W-1:0] cnt_of(input int p);
    return (p == 1) ? pkt_cnt1 : pkt_cnt0;
  endfunction

  task automatic pulse_reset();
    trn_reset = 1'b1;
    tick();
    trn_reset = 1'b0;
  endtask

  // Source-side driver for one packet. The caller owns reqN. kill_beat >= 0 kills the packet on that beat, using discontinue or link-down.
  task automatic xfer(input int p, input int nbeats, input bit toggle, input int kill_beat, input bit kill_link);
    int w;
    bit done;
    logic [63:0] d;
    logic [CNT_W-1:0] cnt_before;
    w = 0;
    #1;
    while (!(gnt0 | gnt1) && w < 20) begin
      tick(); #1; w++;
    end
    check("grant_port", 64'({gnt1, gnt0}), (p == 0) ? 64'd1 : 64'd2);
    cnt_before = cnt_of(p);
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom};
      set_src(p, d, 8'(b), (b == 0) ? 1'b0 : 1'b1, (b == nbeats - 1) ? 1'b0 : 1'b1, 1'b0);
      done = 0;
      w = 0;
      while (!done && w < 20) begin
        trn_tdst_rdy_n = toggle && (w % 2 == 0);
        if (b == kill_beat) begin
          if (kill_link) trn_lnk_up_n = 1'b1;
          else           trn_tdst_dsc_n = 1'b0;
        end
        #1;
        check("other_dst_rdy", 64'(dst_of(1 - p)), 64'd1);
        if (!trn_tdst_rdy_n) begin
          check("beat_td", trn_td, d);
          check("beat_trem", 64'(trn_trem_n), 64'(b));
          check("beat_ctl", 64'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, dst_of(p)}),
                64'({(b == 0) ? 1'b0 : 1'b1, (b == nbeats - 1) ? 1'b0 : 1'b1, 1'b0, 1'b0}));
          done = 1;
        end else begin
          check("stall_dst_rdy", 64'(dst_of(p)), 64'd1);
        end
        if (b == kill_beat) done = 1;
        tick();
        w++;
      end
      if (b == kill_beat) begin
        trn_tdst_dsc_n = 1'b1;
        trn_lnk_up_n   = 1'b0;
        set_src(p, 64'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        #1;
        check("abort_pulse", 64'(abort_of(p)), 64'd1);
        check("abort_gnt", 64'(gnt_of(p)), 64'd0);
        check("abort_cnt", 64'(cnt_of(p)), 64'(cnt_before));
        tick(); #1;
        check("abort_end", 64'(abort_of(p)), 64'd0);
        return;
      end
    end
    set_src(p, 64'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    trn_tdst_rdy_n = 1'b0;
    #1;
    check("eof_gnt", 64'(gnt_of(p)), 64'd0);
    check("eof_cnt", 64'(cnt_of(p)), 64'(CNT_W'(cnt_before + 1'b1)));
  endtask

  // Reference model: who owns the link, who won the last tie, packet counts.
  int m_owner;
  int m_last;
  int m_cnt[2];
  bit m_abort[2];

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0; m_abort[0] = 0; m_abort[1] = 0;
  endtask

  task automatic model_step();
    bit e0, e1, src_rdy, eof;
    int p;
    if (trn_reset) begin
      model_reset();
      return;
    end
    m_abort[0] = 0;
    m_abort[1] = 0;
    if (m_owner < 0) begin
      e0 = req0 && trn_tbuf_av[1] && !trn_lnk_up_n;
      e1 = req1 && trn_tbuf_av[2] && !trn_lnk_up_n;
      if (e0 && e1) begin
        m_owner = 1 - m_last;
        m_last  = m_owner;
      end else if (e0) m_owner = 0;
      else if (e1)     m_owner = 1;
    end else begin
      p       = m_owner;
      src_rdy = (p == 1) ? !s1_tsrc_rdy_n : !s0_tsrc_rdy_n;
      eof     = (p == 1) ? !s1_teof_n : !s0_teof_n;
      if (!trn_tdst_dsc_n || trn_lnk_up_n) begin
        m_abort[p] = 1;
        m_owner    = -1;
      end else if (src_rdy && !trn_tdst_rdy_n && eof) begin
        m_cnt[p] = (m_cnt[p] + 1) % (1 << CNT_W);
        m_owner  = -1;
      end
    end
  endtask

  task automatic model_compare();
    logic [63:0] e_td;
    logic [7:0]  e_trem;
    logic [2:0]  e_ctl;
    logic [1:0]  e_dst;
    e_td = '0; e_trem = '0; e_ctl = 3'b111; e_dst = 2'b11;
    if (m_owner == 0) begin
      e_td = s0_td; e_trem = s0_trem_n; e_ctl = {s0_tsof_n, s0_teof_n, s0_tsrc_rdy_n};
      e_dst = {1'b1, trn_tdst_rdy_n};
    end else if (m_owner == 1) begin
      e_td = s1_td; e_trem = s1_trem_n; e_ctl = {s1_tsof_n, s1_teof_n, s1_tsrc_rdy_n};
      e_dst = {trn_tdst_rdy_n, 1'b1};
    end
    check("rand_gnt_abort", 64'({gnt1, gnt0, abort1, abort0}),
          64'({m_owner == 1, m_owner == 0, m_abort[1], m_abort[0]}));
    check("rand_td", trn_td, e_td);
    check("rand_ctl", 64'({trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, s1_tdst_rdy_n, s0_tdst_rdy_n}),
          64'({e_trem, e_ctl, e_dst}));
    check("rand_cnt", 64'({pkt_cnt1, pkt_cnt0}), 64'({CNT_W'(m_cnt[1]), CNT_W'(m_cnt[0])}));
  endtask

  typedef struct packed {
    logic       req0, req1;
    logic [3:0] tbuf;
    logic       lnk_n;
    logic [1:0] gnt;  // {gnt1, gnt0} one cycle after the decision
  } vec_t;

  vec_t vecs [10];
  int w;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'b1111, 1'b0, 2'b00};
    vecs[1] = '{1'b1, 1'b0, 4'b0010, 1'b0, 2'b01};
    vecs[2] = '{1'b0, 1'b1, 4'b0010, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 1'b1, 4'b0100, 1'b0, 2'b10};
    vecs[4] = '{1'b1, 1'b1, 4'b0110, 1'b0, 2'b01};
    vecs[5] = '{1'b1, 1'b1, 4'b0010, 1'b0, 2'b01};
    vecs[6] = '{1'b1, 1'b1, 4'b0100, 1'b0, 2'b10};
    vecs[7] = '{1'b1, 1'b0, 4'b1111, 1'b1, 2'b00};
    vecs[8] = '{1'b1, 1'b1, 4'b1001, 1'b0, 2'b00};
    vecs[9] = '{1'b0, 1'b1, 4'b1111, 1'b0, 2'b10};

    trn_reset = 1'b1; trn_lnk_up_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    trn_tdst_rdy_n = 1'b0; trn_tdst_dsc_n = 1'b1; trn_tbuf_av = 4'b0000;
    set_src(0, 64'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    set_src(1, 64'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    trn_reset = 1'b0;
    #1;
    check("reset_gnt_abort", 64'({gnt1, gnt0, abort1, abort0}), 64'd0);
    check("reset_cnt", 64'({pkt_cnt1, pkt_cnt0}), 64'd0);
    check("reset_td", trn_td, 64'd0);
    check("reset_ctl", 64'({trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, s1_tdst_rdy_n, s0_tdst_rdy_n}),
          64'({8'h00, 5'b11111}));

    // Grant decision from a fresh reset for each vector.
    for (int i = 0; i < 10; i++) begin
      pulse_reset();
      req0 = vecs[i].req0; req1 = vecs[i].req1;
      trn_tbuf_av = vecs[i].tbuf; trn_lnk_up_n = vecs[i].lnk_n;
      tick(); #1;
      check($sformatf("vec%0d_gnt", i), 64'({gnt1, gnt0}), 64'(vecs[i].gnt));
      req0 = 1'b0; req1 = 1'b0; trn_lnk_up_n = 1'b0;
    end

    // Single 3-beat packet on port 0 with one-cycle grant latency.
    pulse_reset();
    req0 = 1'b1; trn_tbuf_av = 4'b0010;
    #1;
    check("p0_gnt_before", 64'(gnt0), 64'd0);
    tick(); #1;
    check("p0_gnt_latency", 64'(gnt0), 64'd1);
    xfer(0, 3, 1'b0, -1, 1'b0);
    req0 = 1'b0;
    check("p0_cnt", 64'(pkt_cnt0), 64'd1);

    // Continuous ties with 2-beat packets alternate 0,1,0,1.
    pulse_reset();
    req0 = 1'b1; req1 = 1'b1; trn_tbuf_av = 4'b0110;
    for (int k = 0; k < 4; k++) xfer(k % 2, 2, 1'b0, -1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    check("rr_cnts", 64'({pkt_cnt1, pkt_cnt0}), 64'({CNT_W'(2), CNT_W'(2)}));

    // Port 1 blocked by its buffer bit until it is set.
    pulse_reset();
    req1 = 1'b1; trn_tbuf_av = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("buf_block", 64'({gnt1, gnt0}), 64'd0);
    end
    trn_tbuf_av = 4'b0110;
    tick(); #1;
    check("buf_release", 64'(gnt1), 64'd1);
    xfer(1, 1, 1'b0, -1, 1'b0);
    req1 = 1'b0;

    // Backpressure toggling on a 4-beat port-0 packet.
    req0 = 1'b1;
    xfer(0, 4, 1'b1, -1, 1'b0);
    req0 = 1'b0;

    // Discontinue on beat 2 of a port-1 packet, then the retry.
    req1 = 1'b1;
    xfer(1, 3, 1'b0, 1, 1'b0);
    xfer(1, 3, 1'b0, -1, 1'b0);
    req1 = 1'b0;
    // Discontinue on a single-beat eof, then link loss mid-packet.
    req0 = 1'b1;
    xfer(0, 1, 1'b0, 0, 1'b0);
    xfer(0, 2, 1'b0, 1, 1'b1);
    xfer(0, 1, 1'b0, -1, 1'b0);
    req0 = 1'b0;
    check("kill_cnts", 64'({pkt_cnt1, pkt_cnt0}), 64'({CNT_W'(2), CNT_W'(2)}));

    // Reset in the middle of a packet.
    req0 = 1'b1;
    tick(); #1;
    check("mid_gnt", 64'(gnt0), 64'd1);
    set_src(0, 64'h1234, 8'd0, 1'b0, 1'b1, 1'b0);
    trn_tdst_rdy_n = 1'b1;
    trn_reset = 1'b1;
    tick(); #1;
    check("mid_reset_gnt", 64'({gnt1, gnt0}), 64'd0);
    check("mid_reset_src", 64'(trn_tsrc_rdy_n), 64'd1);
    check("mid_reset_cnt", 64'({pkt_cnt1, pkt_cnt0}), 64'd0);
    trn_reset = 1'b0; req0 = 1'b0; trn_tdst_rdy_n = 1'b0;
    set_src(0, 64'd0, 8'd0, 1'b1, 1'b1, 1'b1);

    // Counter wrap using back-to-back single-beat packets.
    pulse_reset();
    req0 = 1'b1; trn_tbuf_av = 4'b0010;
    set_src(0, 64'hCAFE, 8'd0, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (pkt_cnt0 != CNT_MAX && w < 8 << CNT_W) begin
      tick(); w++;
    end
    check("wrap_reach_max", 64'(pkt_cnt0), 64'(CNT_MAX));
    tick(); tick(); #1;
    check("wrap_zero", 64'(pkt_cnt0), 64'd0);
    req0 = 1'b0;
    set_src(0, 64'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    tick();

    // Randomized run against the reference model.
    pulse_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      trn_reset      = ($urandom_range(0, 399) == 0);
      req0           = ($urandom_range(0, 3) != 0);
      req1           = ($urandom_range(0, 3) != 0);
      trn_tbuf_av    = 4'($urandom);
      trn_lnk_up_n   = ($urandom_range(0, 31) == 0);
      trn_tdst_dsc_n = ($urandom_range(0, 31) != 0);
      trn_tdst_rdy_n = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < 2; p++)
        set_src(p, {$urandom, $urandom}, 8'($urandom), 1'($urandom),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
      #1;
      model_compare();
      model_step();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_tlp_arbiter.md
Name: tx_tlp_arbiter

Overview:
- Shares the single PCIe TX local-link (trn_td/trn_tsof_n/...) between two TLP sources.
- Port 0 is the posted-write packet engine (RX packets to hugepages). Port 1 is the completion engine (BAR/MDIO read completions).
- Grants are packet-atomic, round-robin, and gated by trn_tbuf_av. The data path is a zero-latency mux driven by a registered grant.

Parameters:
- P0_BUF_BIT, 1, trn_tbuf_av bit that must be 1 before granting port 0 (posted).
- P1_BUF_BIT, 2, trn_tbuf_av bit that must be 1 before granting port 1 (completion).
- CNT_W, 16, width of the per-port packet counters.

Ports:
- trn_clk  in  1  sole clock
- trn_reset  in  1  synchronous, active-high reset
- trn_lnk_up_n  in  1  link up, active low
- req0, req1  in  1 each  requester has a full TLP ready; held until its eof beat is accepted
- gnt0, gnt1  out  1 each  registered grant; one-hot or zero
- abort0, abort1  out  1 each  one-cycle pulse: granted packet was discontinued
- s0_td, s1_td  in  64 each  requester data
- s0_trem_n, s1_trem_n  in  8 each  requester remainder
- s0_tsof_n, s1_tsof_n, s0_teof_n, s1_teof_n, s0_tsrc_rdy_n, s1_tsrc_rdy_n  in  1 each
- s0_tdst_rdy_n, s1_tdst_rdy_n  out  1 each
- trn_td  out  64
- trn_trem_n  out  8
- trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  1 each
- trn_tdst_rdy_n  in  1
- trn_tdst_dsc_n  in  1
- trn_tbuf_av  in  4
- pkt_cnt0, pkt_cnt1  out  CNT_W each  completed packets per port, wrapping

Behaviour:
- Reset: state=IDLE; gnt0=gnt1=0; abort0=abort1=0; last=1 (port 0 wins the first tie); pkt_cnt0=pkt_cnt1=0.
- States: IDLE, XFER0, XFER1. gntN=1 exactly while in XFERN.
- Eligibility: eligN = reqN & trn_tbuf_av[PN_BUF_BIT] & ~trn_lnk_up_n.
- IDLE transitions:
  - only elig0 -> XFER0; only elig1 -> XFER1.
  - both eligible -> XFERx where x != last; set last=x on entry.
  - neither eligible -> stay in IDLE.
- Grant takes effect the cycle after the decision. There is always at least one IDLE cycle between packets.
- Mux, combinational from state:
  - In XFERN: trn_td/trem_n/tsof_n/teof_n/tsrc_rdy_n = sN_*; sN_tdst_rdy_n = trn_tdst_rdy_n; the other port's tdst_rdy_n=1.
  - In IDLE: trn_td=0, trn_trem_n=0, trn_tsof_n=trn_teof_n=trn_tsrc_rdy_n=1; both sN_tdst_rdy_n=1.
- Beat accepted when ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n in XFERN.
- Accepted beat with teof_n=0: next state IDLE; pkt_cntN += 1, wrapping at 2^CNT_W.
- Single-beat packets (sof and eof together) are legal and handled the same way.
- reqN is ignored while in XFERN. A requester deasserting req mid-packet has no effect; the packet ends only on eof or abort.
- trn_tdst_dsc_n=0 in XFERN: next state IDLE; abortN pulses one cycle; pkt_cntN unchanged. The requester drops the packet and may re-request.
- trn_lnk_up_n=1 in XFERN: same as discontinue (abortN pulse, go to IDLE). No grants are issued while the link is down.
- Discontinue together with an accepted eof beat: discontinue wins, abort pulses, no count.
- trn_tbuf_av is checked only at grant time; a drop mid-packet is ignored.
- trn_reset mid-packet: immediate return to reset values on the next edge; outputs are idle-valued from that edge on.

Test Plan:
- Post-reset, only req0=1, tbuf_av=4'b0010 -> gnt0 rises 1 cycle later. A 3-beat packet passes through unchanged. After the eof beat: IDLE, gnt0=0, pkt_cnt0=1.
- req0=req1=1 continuously, tbuf_av=4'b0110, 2-beat packets -> grants alternate 0,1,0,1. The first grant is port 0. After 4 packets pkt_cnt0=2 and pkt_cnt1=2.
- req1=1, tbuf_av=4'b0010 (bit 2 clear) -> no grant. Set bit 2 -> gnt1 the following cycle.
- trn_tdst_rdy_n toggling 1/0 during a 4-beat port-0 packet -> trn_td sequence equals s0_td accepted beats in order. s1_tdst_rdy_n stays 1 throughout.
- Pull trn_tdst_dsc_n low on beat 2 of a port-1 packet -> abort1 is a 1-cycle pulse; state returns to IDLE; pkt_cnt1 is unchanged. Re-request -> the packet is granted again.
- Assert trn_reset mid-packet -> next cycle gnt0=gnt1=0, trn_tsrc_rdy_n=1, counters=0. Drive pkt_cnt0 to 16'hFFFF and complete one more packet -> pkt_cnt0=0.
